// File: rtl/countdown_timer.sv
// MM:SS countdown timer with preset load from switches, start/pause button and
// an alarm at 00:00. Raw buttons are synchronised and debounced internally.
module countdown_timer #(
  parameter int TICKS_PER_SEC   = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic [7:0] sw,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       running,
  output logic       expired,
  output logic       sec_tick
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_n;
  logic [15:0]   tm, tm_n;
  logic [PW-1:0] presc, presc_n;
  logic          running_n, expired_n;

  logic [1:0]    btn_raw, sync_p0, sync_p1, db_lvl, db_lvl_q, press;
  logic [CW-1:0] db_cnt [2];
  logic          go, ld, tick, nonzero, at_one;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // BCD borrow chain across sec0 -> sec1 -> min0 -> min1
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign btn_raw = {btn_load, btn_start};

  // Stage p0/p1: synchroniser, then debounce against the accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      db_lvl_q <= db_lvl;
      press    <= db_lvl & ~db_lvl_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign go      = press[0];
  assign ld      = press[1] && (state != RUN);
  assign nonzero = |tm;
  assign at_one  = (tm == 16'h0001);
  // A start press in RUN pauses before the second can expire
  assign tick    = (state == RUN) && !go && (presc == PRESC_MAX) && nonzero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tm       <= '0;
      presc    <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      state    <= state_n;
      tm       <= tm_n;
      presc    <= presc_n;
      running  <= running_n;
      expired  <= expired_n;
      sec_tick <= tick;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!ld && go && nonzero) state_n = RUN;
      RUN: begin
        if (go)                  state_n = PAUSE;
        else if (tick && at_one) state_n = DONE;
      end
      PAUSE: begin
        if (ld)      state_n = IDLE;
        else if (go) state_n = RUN;
      end
      DONE:    if (ld || go) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tm_n      = tm;
    presc_n   = presc;
    running_n = (state_n == RUN);
    expired_n = (state_n == DONE);
    if (ld) begin
      tm_n    = {clamp_bcd(sw[7:4], 4'd5), clamp_bcd(sw[3:0], 4'd9), 8'h00};
      presc_n = '0;
    end else if (state == RUN && !go) begin
      presc_n = (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      if (tick) tm_n = bcd_dec(tm);
    end
  end

  assign {min1, min0, sec1, sec0} = tm;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=10, DEBOUNCE_CYCLES=4.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_load;
  logic [7:0] sw;
  logic [3:0] min1, min0, sec1, sec0;
  logic       running, expired, sec_tick;
  logic [15:0] digits;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  countdown_timer #(.TICKS_PER_SEC(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_load(btn_load), .sw(sw),
    .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
    .running(running), .expired(expired), .sec_tick(sec_tick)
  );

  assign digits = {min1, min0, sec1, sec0};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_btns(input bit s, input bit l);
    btn_start = s;
    btn_load  = l;
    repeat (10) @(negedge clk);
    btn_start = 1'b0;
    btn_load  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_tick(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!sec_tick && waited < limit);
    if (!sec_tick) waited = -1;
  endtask

  task automatic wait_run(input bit want, input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (running !== want && waited < limit);
    if (running !== want) waited = -1;
  endtask

  initial begin
    int w, first, pulses, bad;
    logic [6:0] bounce;

    // Reset
    rst_n = 1'b0; btn_start = 1'b0; btn_load = 1'b0; sw = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_expired", expired, 1'b0);
    chk("rst_sec_tick", sec_tick, 1'b0);
    rst_n = 1'b1;

    // Load 12:00 and measure the debounced press pulse
    sw = 8'h12; btn_load = 1'b1;
    first = -1; pulses = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (dut.press[1]) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 10) btn_load = 1'b0;
    end
    chk("load_press_lat", first, 7);
    chk("load_press_width", pulses, 1);
    chk("load_digits", digits, 16'h1200);
    chk("load_expired", expired, 1'b0);
    chk("load_running", running, 1'b0);

    // Borrow chain from 01:00
    sw = 8'h01; press_btns(1'b0, 1'b1);
    chk("bc_load", digits, 16'h0100);
    btn_start = 1'b1;
    wait_run(1'b1, 20, w);
    btn_start = 1'b0;
    chk("bc_start_lat", w, 8);
    wait_tick(20, w);
    chk("bc_first_tick", w, 10);
    chk("bc_first_digits", digits, 16'h0059);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      wait_tick(20, w);
      if (w != 10) bad++;
    end
    chk("bc_intervals", bad, 0);
    chk("bc_tick10", digits, 16'h0050);

    // Terminal count at tick 60
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      wait_tick(20, w);
      if (w != 10) bad++;
    end
    chk("tc_intervals", bad, 0);
    chk("tc_tick59", digits, 16'h0001);
    chk("tc_running59", running, 1'b1);
    wait_tick(20, w);
    chk("tc_tick60_lat", w, 10);
    chk("tc_zero", digits, 16'h0000);
    chk("tc_expired", expired, 1'b1);
    chk("tc_running", running, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (digits !== 16'h0000 || expired !== 1'b1 || sec_tick !== 1'b0 || running !== 1'b0) bad++;
    end
    chk("tc_hold", bad, 0);
    press_btns(1'b1, 1'b0);
    chk("ack_expired", expired, 1'b0);
    chk("ack_running", running, 1'b0);
    chk("ack_digits", digits, 16'h0000);
    chk("ack_state", dut.state, 0);

    // Pause at prescaler 6, resume, next decrement 4 cycles later
    sw = 8'h02; press_btns(1'b0, 1'b1);
    chk("p_load", digits, 16'h0200);
    btn_start = 1'b1;
    wait_run(1'b1, 20, w);
    btn_start = 1'b0;
    wait_tick(20, w);
    chk("p_first_tick", w, 10);
    repeat (9) @(negedge clk);
    btn_start = 1'b1;
    wait_run(1'b0, 20, w);
    btn_start = 1'b0;
    chk("p_pause_lat", w, 8);
    chk("p_presc", dut.presc, 6);
    chk("p_digits", digits, 16'h0158);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sec_tick !== 1'b0 || running !== 1'b0) bad++;
    end
    chk("p_hold", bad, 0);
    chk("p_presc_held", dut.presc, 6);
    btn_start = 1'b1;
    wait_run(1'b1, 20, w);
    btn_start = 1'b0;
    wait_tick(20, w);
    chk("p_resume_lat", w, 4);
    chk("p_resume_digits", digits, 16'h0157);

    // Load while running is ignored
    sw = 8'h33; press_btns(1'b0, 1'b1);
    chk("run_load_running", running, 1'b1);
    chk("run_load_digits", digits, 16'h0155);

    // Start bounce of 2-cycle widths produces no press
    bounce = 7'b0110011;
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      btn_start = (i < 7) ? bounce[6 - i] : 1'b0;
      @(negedge clk);
      if (dut.press[0]) pulses++;
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_running", running, 1'b1);

    // Simultaneous start+load in PAUSE: load wins, with clamping
    btn_start = 1'b1;
    wait_run(1'b0, 20, w);
    btn_start = 1'b0;
    repeat (12) @(negedge clk);
    chk("sim_paused", dut.state, 2);
    sw = 8'h7C; press_btns(1'b1, 1'b1);
    chk("sim_digits", digits, 16'h5900);
    chk("sim_state", dut.state, 0);
    repeat (20) @(negedge clk);
    chk("sim_running", running, 1'b0);
    sw = 8'h96; press_btns(1'b0, 1'b1);
    chk("clamp_min1", digits, 16'h5600);

    // Start in IDLE at 00:00 stays IDLE
    sw = 8'h00; press_btns(1'b0, 1'b1);
    chk("empty_load", digits, 16'h0000);
    press_btns(1'b1, 1'b0);
    chk("empty_running", running, 1'b0);
    chk("empty_state", dut.state, 0);

    // Reset mid-count
    sw = 8'h03; press_btns(1'b0, 1'b1);
    btn_start = 1'b1;
    wait_run(1'b1, 20, w);
    btn_start = 1'b0;
    wait_tick(20, w);
    chk("mid_tick", digits, 16'h0259);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_digits", digits, 16'h0000);
    chk("mid_rst_running", running, 1'b0);
    chk("mid_rst_presc", dut.presc, 0);
    repeat (20) @(negedge clk);
    chk("mid_rst_idle", dut.state, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
